// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: direction encoding and the
// modulo next-count helper reused by timer blocks.
package counter_pkg;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Next value of a modulo-mod counter stepping one position in direction up.
    function automatic logic [31:0] next_mod_count(
        input logic [31:0] cur,
        input logic        up,
        input logic [31:0] mod
    );
        logic [31:0] nxt;
        if (up == DIR_UP) begin
            if (cur >= (mod - 32'd1)) begin
                nxt = 32'd0;
            end else begin
                nxt = cur + 32'd1;
            end
        end else begin
            if (cur == 32'd0) begin
                nxt = mod - 32'd1;
            end else begin
                nxt = cur - 32'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/counter_bound_detect.sv
// Combinational bound flags and terminal count for a modulo-MOD counter.
module counter_bound_detect
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  logic             up,
    output logic             at_max,
    output logic             at_min,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    // Bound comparisons and the enable-qualified terminal count.
    always_comb begin
        at_max = (count == MAX_VAL);
        at_min = (count == {WIDTH{1'b0}});
        tc     = en & (((up == DIR_UP) & at_max) | ((up == DIR_DOWN) & at_min));
    end

endmodule

// File: rtl/sync_updown_counter.sv
// Fully synchronous loadable up/down modulo counter with terminal-count,
// wrap pulse and saturation status.
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MOD      = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic           SAT_EN     = (SATURATE != 0);
    localparam logic [WIDTH:0] MAX_VAL_EXT = (WIDTH + 1)'(MOD - 1);

    logic [WIDTH-1:0] count_r;
    logic             wrap_r;
    logic             sat_r;
    logic             at_max_s;
    logic             at_min_s;
    logic             tc_s;
    logic             at_bound_s;
    logic [WIDTH-1:0] next_s;
    logic [WIDTH-1:0] load_clamp_s;

    counter_bound_detect #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_bound (
        .count  (count_r),
        .en     (en),
        .up     (up),
        .at_max (at_max_s),
        .at_min (at_min_s),
        .tc     (tc_s)
    );

    // Next-count, bound selection and load clamping; the clamp compares in
    // WIDTH+1 bits so MOD == 2**WIDTH needs no special case.
    always_comb begin
        next_s     = WIDTH'(next_mod_count(32'(count_r), up, 32'(MOD)));
        at_bound_s = (up == DIR_UP) ? at_max_s : at_min_s;
        if ({1'b0, load_val} > MAX_VAL_EXT) begin
            load_clamp_s = MAX_VAL_EXT[WIDTH-1:0];
        end else begin
            load_clamp_s = load_val;
        end
    end

    // Count and status registers, priority rst > load > en > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
            wrap_r  <= 1'b0;
            sat_r   <= 1'b0;
        end else if (load) begin
            count_r <= load_clamp_s;
            wrap_r  <= 1'b0;
            sat_r   <= 1'b0;
        end else if (en) begin
            if (at_bound_s && SAT_EN) begin
                wrap_r <= 1'b0;
                sat_r  <= 1'b1;
            end else begin
                count_r <= next_s;
                wrap_r  <= at_bound_s;
                sat_r   <= 1'b0;
            end
        end else begin
            wrap_r <= 1'b0;
        end
    end

    assign count = count_r;
    assign tc    = tc_s;
    assign wrap  = wrap_r;
    assign sat   = sat_r;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench: a wrapping MOD=10 instance and a saturating MOD=16 instance.
module tb_sync_updown_counter;

    logic       clk = 1'b0;
    logic       rst_w, en_w, up_w, load_w;
    logic [3:0] load_val_w;
    logic [3:0] count_w;
    logic       tc_w, wrap_w, sat_w;
    logic       rst_s, en_s, up_s, load_s;
    logic [3:0] load_val_s;
    logic [3:0] count_s;
    logic       tc_s, wrap_s, sat_s;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    sync_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst_w), .en(en_w), .up(up_w), .load(load_w),
        .load_val(load_val_w), .count(count_w), .tc(tc_w), .wrap(wrap_w), .sat(sat_w)
    );

    sync_updown_counter #(.WIDTH(4), .MOD(16), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst_s), .en(en_s), .up(up_s), .load(load_s),
        .load_val(load_val_s), .count(count_s), .tc(tc_s), .wrap(wrap_s), .sat(sat_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_w = 1'b1; en_w = 1'b0; up_w = 1'b1; load_w = 1'b0; load_val_w = 4'd0;
        rst_s = 1'b1; en_s = 1'b0; up_s = 1'b1; load_s = 1'b0; load_val_s = 4'd0;
        step();
        check("rst_count", 32'(count_w), 32'd0);
        check("rst_wrap", 32'(wrap_w), 32'd0);
        check("rst_sat", 32'(sat_w), 32'd0);
        check("rst_tc", 32'(tc_w), 32'd0);
        check("rst_count_s", 32'(count_s), 32'd0);
        check("rst_sat_s", 32'(sat_s), 32'd0);

        // Count up through the wrap: 1..9, 0, 1.
        rst_w = 1'b0; rst_s = 1'b0; en_w = 1'b1; up_w = 1'b1;
        settle();
        check("up_tc_at0", 32'(tc_w), 32'd0);
        for (int i = 1; i <= 11; i++) begin
            step();
            check("up_count", 32'(count_w), 32'(i % 10));
            check("up_wrap", 32'(wrap_w), (i == 10) ? 32'd1 : 32'd0);
            check("up_tc", 32'(tc_w), (i == 9) ? 32'd1 : 32'd0);
        end

        // Down from 0 wraps to 9, then 8, 7.
        load_w = 1'b1; load_val_w = 4'd0;
        step();
        check("ld0_count", 32'(count_w), 32'd0);
        load_w = 1'b0; up_w = 1'b0;
        settle();
        check("dn_tc_at0", 32'(tc_w), 32'd1);
        step();
        check("dn_count9", 32'(count_w), 32'd9);
        check("dn_wrap9", 32'(wrap_w), 32'd1);
        step();
        check("dn_count8", 32'(count_w), 32'd8);
        check("dn_wrap8", 32'(wrap_w), 32'd0);
        step();
        check("dn_count7", 32'(count_w), 32'd7);

        // Out-of-range load clamps to 9 and beats a simultaneous enable.
        load_w = 1'b1; load_val_w = 4'd12; up_w = 1'b1;
        step();
        check("ld12_count", 32'(count_w), 32'd9);
        check("ld12_wrap", 32'(wrap_w), 32'd0);
        settle();
        check("ld_tc_pending", 32'(tc_w), 32'd1);
        step();
        check("ld_over_tc_count", 32'(count_w), 32'd9);
        check("ld_over_tc_wrap", 32'(wrap_w), 32'd0);

        // Reset beats load and enable.
        load_val_w = 4'd5;
        step();
        check("ld5_count", 32'(count_w), 32'd5);
        rst_w = 1'b1; load_val_w = 4'd3;
        step();
        check("rst_mid_count", 32'(count_w), 32'd0);
        check("rst_mid_wrap", 32'(wrap_w), 32'd0);
        check("rst_mid_sat", 32'(sat_w), 32'd0);

        // Enable gap with a direction flip: 5, 5, 4.
        rst_w = 1'b0; load_val_w = 4'd4;
        step();
        check("ld4_count", 32'(count_w), 32'd4);
        load_w = 1'b0; en_w = 1'b1; up_w = 1'b1;
        step();
        check("gap_count5", 32'(count_w), 32'd5);
        en_w = 1'b0; up_w = 1'b0;
        settle();
        check("gap_tc_off", 32'(tc_w), 32'd0);
        step();
        check("gap_hold5", 32'(count_w), 32'd5);
        en_w = 1'b1;
        step();
        check("gap_count4", 32'(count_w), 32'd4);
        en_w = 1'b0;

        // Saturating instance: 13 -> 14, 15, 15 (sat), 15, then down to 14.
        load_s = 1'b1; load_val_s = 4'd13;
        step();
        check("s_ld13", 32'(count_s), 32'd13);
        load_s = 1'b0; en_s = 1'b1; up_s = 1'b1;
        step();
        check("s_count14", 32'(count_s), 32'd14);
        check("s_sat14", 32'(sat_s), 32'd0);
        step();
        check("s_count15", 32'(count_s), 32'd15);
        check("s_sat15", 32'(sat_s), 32'd0);
        check("s_tc15", 32'(tc_s), 32'd1);
        step();
        check("s_hold15a", 32'(count_s), 32'd15);
        check("s_sat_a", 32'(sat_s), 32'd1);
        check("s_wrap_a", 32'(wrap_s), 32'd0);
        step();
        check("s_hold15b", 32'(count_s), 32'd15);
        check("s_sat_b", 32'(sat_s), 32'd1);
        up_s = 1'b0;
        step();
        check("s_off14", 32'(count_s), 32'd14);
        check("s_off_sat", 32'(sat_s), 32'd0);

        // Saturate at zero, sat holds while disabled, load clears it.
        load_s = 1'b1; load_val_s = 4'd1;
        step();
        load_s = 1'b0;
        step();
        check("s_count0", 32'(count_s), 32'd0);
        check("s_sat0", 32'(sat_s), 32'd0);
        step();
        check("s_hold0", 32'(count_s), 32'd0);
        check("s_sat_low", 32'(sat_s), 32'd1);
        en_s = 1'b0;
        step();
        check("s_sat_held", 32'(sat_s), 32'd1);
        load_s = 1'b1; load_val_s = 4'd7;
        step();
        check("s_ld7", 32'(count_s), 32'd7);
        check("s_ld_sat", 32'(sat_s), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
